// File: rtl/dcache_wt_if.sv
// rtl/dcache_wt_if.sv - CPU-side and bridge-side SRAM-style ports of the data cache
interface dcache_wt_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_finish;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_write_respone;

  modport master (
    output ce, we, addr, wdata, wmask, mem_rdata, mem_rdata_valid, mem_write_respone,
    input  rdata, rdata_valid, write_finish, mem_addr, mem_wdata, mem_wmask, mem_ce, mem_we
  );

  modport slave (
    input  ce, we, addr, wdata, wmask, mem_rdata, mem_rdata_valid, mem_write_respone,
    output rdata, rdata_valid, write_finish, mem_addr, mem_wdata, mem_wmask, mem_ce, mem_we
  );
endinterface

// File: rtl/dcache_wt.sv
// rtl/dcache_wt.sv - direct-mapped write-through no-write-allocate data cache
module dcache_wt #(
  parameter int         INDEX_WIDTH  = 6,
  parameter logic [3:0] UNCACHED_SEG = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  dcache_wt_if.slave  bus
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_RD_MISS, S_RD_UNC, S_WR, S_RESP} state_t;

  state_t state_q, state_d;

  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wmask;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [INDEX_WIDTH-1:0] in_idx, req_idx;
  logic [TAG_W-1:0]       in_tag, req_tag;
  logic                   in_unc, in_hit, req_hit;

  assign in_idx  = bus.addr[INDEX_WIDTH+1:2];
  assign in_tag  = bus.addr[31:INDEX_WIDTH+2];
  assign req_idx = req_addr[INDEX_WIDTH+1:2];
  assign req_tag = req_addr[31:INDEX_WIDTH+2];
  assign in_unc  = (bus.addr[31:28] == UNCACHED_SEG);
  assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag) && !in_unc;
  // Write hits are re-evaluated at the bridge response against the latched address.
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                   && (req_addr[31:28] != UNCACHED_SEG);

  assign bus.rdata_valid  = (state_q == S_RESP) && !req_we;
  assign bus.write_finish = (state_q == S_RESP) && req_we;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ce) begin
          if (bus.we)      state_d = S_WR;
          else if (in_unc) state_d = S_RD_UNC;
          else if (in_hit) state_d = S_RESP;
          else             state_d = S_RD_MISS;
        end
      end
      S_RD_MISS, S_RD_UNC: if (bus.mem_rdata_valid)   state_d = S_RESP;
      S_WR:                if (bus.mem_write_respone) state_d = S_RESP;
      S_RESP:              state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wmask     <= '0;
      bus.rdata     <= '0;
      bus.mem_ce    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ce) begin
            req_we    <= bus.we;
            req_addr  <= bus.addr;
            req_wdata <= bus.wdata;
            req_wmask <= bus.wmask;
            if (bus.we) begin
              bus.mem_ce    <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= bus.addr;
              bus.mem_wdata <= bus.wdata;
              bus.mem_wmask <= bus.wmask;
            end else if (in_unc || !in_hit) begin
              bus.mem_ce    <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
              bus.mem_wdata <= '0;
              bus.mem_wmask <= '0;
            end else begin
              bus.rdata <= data_q[in_idx];
            end
          end
        end
        S_RD_MISS, S_RD_UNC: begin
          if (bus.mem_rdata_valid) begin
            bus.rdata  <= bus.mem_rdata;
            bus.mem_ce <= 1'b0;
          end
        end
        S_WR: begin
          if (bus.mem_write_respone) begin
            bus.mem_ce <= 1'b0;
            bus.mem_we <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      valid_q <= '0;
    else if (state_q == S_RD_MISS && bus.mem_rdata_valid)
      valid_q[req_idx] <= 1'b1;
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state_q == S_RD_MISS && bus.mem_rdata_valid) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= bus.mem_rdata;
    end else if (state_q == S_WR && bus.mem_write_respone && req_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wmask[b]) data_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// tb/tb_dcache_wt.sv - scoreboard bench for dcache_wt with a fixed-latency bridge model
module tb_dcache_wt;
  localparam int BR_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_wt_if bus ();
  dcache_wt #(.INDEX_WIDTH(6), .UNCACHED_SEG(4'hA)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic we; logic [31:0] data; } resp_t;
  resp_t        sb_q[$];
  logic [31:0]  br_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;
  int n_req = 0;
  int br_wait = 0;
  bit br_hold = 0;
  bit stray = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wmask;
  logic        last_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bridge: answers each request BR_LAT cycles after mem_ce is first seen.
  initial begin
    bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0; bus.mem_write_respone = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_rdata_valid = 1'b0;
      bus.mem_write_respone = 1'b0;
      if (stray) begin
        stray = 0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_write_respone = 1'b1;
      end else if (!bus.mem_ce) begin
        br_wait = 0;
      end else if (!br_hold) begin
        br_wait++;
        if (br_wait == 1) begin
          n_req++;
          last_addr = bus.mem_addr; last_we = bus.mem_we;
          last_wdata = bus.mem_wdata; last_wmask = bus.mem_wmask;
        end
        if (br_wait == BR_LAT) begin
          br_wait = 0;
          if (bus.mem_we) bus.mem_write_respone = 1'b1;
          else begin
            bus.mem_rdata = (br_q.size() > 0) ? br_q.pop_front() : 32'hBAD0_BAD0;
            bus.mem_rdata_valid = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.rdata_valid || bus.write_finish)) begin
        if (sb_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("resp_kind", {31'd0, bus.write_finish}, {31'd0, e.we});
          check("resp_both", {31'd0, bus.rdata_valid & bus.write_finish}, 32'd0);
          if (!e.we) check("rdata", bus.rdata, e.data);
        end
        resp_cnt++;
      end
    end
  end

  task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [31:0] bdata,
                         input logic [31:0] exp_data, input bit exp_mem);
    resp_t e;
    int    c0, r0, lat;
    e.we = we; e.data = exp_data;
    sb_q.push_back(e);
    if (exp_mem && !we) br_q.push_back(bdata);
    c0 = resp_cnt; r0 = n_req;
    @(negedge clk);
    bus.ce = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.wmask = wmask;
    @(posedge clk);
    #1 bus.ce = 1'b0;
    lat = 0;
    while (resp_cnt == c0 && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    check("resp_seen", {31'd0, resp_cnt != c0}, 32'd1);
    check("resp_latency", lat, exp_mem ? BR_LAT + 1 : 1);
    check("bridge_reqs", n_req - r0, exp_mem ? 1 : 0);
    if (exp_mem) begin
      check("mem_addr", last_addr, we ? addr : {addr[31:2], 2'b00});
      check("mem_we", {31'd0, last_we}, {31'd0, we});
      if (we) begin
        check("mem_wdata", last_wdata, wdata);
        check("mem_wmask", {28'd0, last_wmask}, {28'd0, wmask});
      end
    end
    check("mem_ce_after", {31'd0, bus.mem_ce}, 32'd0);
    @(negedge clk); #1;
    check("pulse_one_cycle", {31'd0, bus.rdata_valid | bus.write_finish}, 32'd0);
  endtask

  initial begin
    int c0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check("rst_write_finish", {31'd0, bus.write_finish}, 32'd0);
    check("rst_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);

    // cold read then hit
    cpu_req(0, 32'h1C00_0040, 0, 0, 32'h1234_5678, 32'h1234_5678, 1);
    cpu_req(0, 32'h1C00_0040, 0, 0, 0,             32'h1234_5678, 0);
    // partial write hit, then hit read of merged word
    cpu_req(1, 32'h1C00_0040, 32'hAABB_CCDD, 4'b0101, 0, 0, 1);
    cpu_req(0, 32'h1C00_0040, 0, 0, 0, 32'h12BB_56DD, 0);
    // zero-mask write is forwarded and leaves the line alone
    cpu_req(1, 32'h1C00_0041, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1);
    cpu_req(0, 32'h1C00_0043, 0, 0, 0, 32'h12BB_56DD, 0);
    // write miss does not allocate
    cpu_req(1, 32'h1C00_0080, 32'h0000_0077, 4'b1111, 0, 0, 1);
    cpu_req(0, 32'h1C00_0080, 0, 0, 32'h0000_0088, 32'h0000_0088, 1);
    // index conflict
    cpu_req(0, 32'h1C00_0000, 0, 0, 32'h1, 32'h1, 1);
    cpu_req(0, 32'h1C00_0100, 0, 0, 32'h2, 32'h2, 1);
    cpu_req(0, 32'h1C00_0000, 0, 0, 32'h1, 32'h1, 1);
    // uncached reads always go to the bridge
    cpu_req(0, 32'hA000_0000, 0, 0, 32'h5, 32'h5, 1);
    cpu_req(0, 32'hA000_0002, 0, 0, 32'h6, 32'h6, 1);

    // reset while in RD_MISS, then a late bridge pulse
    br_hold = 1;
    c0 = resp_cnt;
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h1C00_0100;
    @(posedge clk);
    #1 bus.ce = 1'b0;
    repeat (2) @(negedge clk);
    check("miss_mem_ce", {31'd0, bus.mem_ce}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
    stray = 1;
    br_hold = 0;
    repeat (4) @(negedge clk);
    #1;
    check("stray_ignored", resp_cnt - c0, 32'd0);
    check("stray_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
    cpu_req(0, 32'h1C00_0100, 0, 0, 32'h99, 32'h99, 1);
    cpu_req(0, 32'h1C00_0040, 0, 0, 32'h42, 32'h42, 1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage's SRAM-style data port and the data port of `sram2axi4_lite`. It serves MEM loads from on-chip storage on a hit and forwards misses, uncached accesses and all stores to the bridge. Both sides use the same request/valid protocol as `ICache`, so the cache drops into the existing data path without changes to MEM or the bridge.

## Interface
Parameters:
- `INDEX_WIDTH`, 6: line index bits; 2^INDEX_WIDTH one-word lines; index = `addr[INDEX_WIDTH+1:2]`, tag = `addr[31:INDEX_WIDTH+2]`.
- `UNCACHED_SEG`, 4'hA: accesses with `addr[31:28] == UNCACHED_SEG` bypass the cache (MMIO).

Ports:
- `clk` in 1: clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: CPU request. Held with stable `we/addr/wdata/wmask` until response.
- `we` in 1: 0 read, 1 write.
- `addr` in 32: byte address. Bits [1:0] are ignored for lookup and forwarded unchanged.
- `wdata` in 32, `wmask` in 4: store data and byte enables.
- `rdata` out 32: load data. Registered and held between responses.
- `rdata_valid` out 1: one-cycle pulse that completes a read.
- `write_finish` out 1: one-cycle pulse that completes a write.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_wmask` out 4, `mem_ce` out 1, `mem_we` out 1: bridge request.
- `mem_rdata` in 32, `mem_rdata_valid` in 1: bridge read data and its one-cycle valid.
- `mem_write_respone` in 1: bridge write-complete pulse.

## Operation
Storage:
- Per line: `valid` bit, tag, 32-bit data word.
- All `valid` bits are cleared by `reset` in one cycle. Data and tag arrays are not reset.

FSM states: IDLE, RD_MISS, RD_UNC, WR, RESP.
- IDLE, `ce=1`: the request is accepted this cycle. `hit = valid[idx] && tag[idx]==addr_tag && !uncached`.
  - Read hit: load `rdata <= data[idx]`, go to RESP.
  - Read miss: go to RD_MISS.
  - Uncached read: go to RD_UNC.
  - Any write: go to WR.
  - Request fields are latched at acceptance. Internal logic uses the latched copy.
- RD_MISS / RD_UNC: `mem_ce=1`, `mem_we=0`, `mem_addr={latched addr[31:2],2'b00}`.
  - On `mem_rdata_valid`: `rdata <= mem_rdata`, go to RESP.
  - RD_MISS additionally fills the line: `valid=1`, tag, data. RD_UNC leaves the array untouched.
- WR: `mem_ce=1`, `mem_we=1`, `mem_addr`=latched addr, `mem_wdata`/`mem_wmask` = latched values.
  - On `mem_write_respone`: if the latched access is a cached hit (re-checked at this point), merge `wdata` into the line byte-wise per `wmask`.
  - Misses do not allocate. Then go to RESP.
- RESP: pulse `rdata_valid` (read) or `write_finish` (write) for exactly one cycle, then go to IDLE.
- `ce` is ignored in every state except IDLE. Stray `mem_rdata_valid` or `mem_write_respone` pulses in IDLE or RESP are ignored.
- `wmask=4'h0` writes are still forwarded to the bridge. The merge is a no-op.

## Timing
- Reset values:
  - `rdata=0`, `rdata_valid=0`, `write_finish=0`.
  - `mem_ce=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wmask=0`.
  - FSM = IDLE.
- Read hit: accepted at cycle T, `rdata_valid` at T+1.
- Miss, uncached or write: `mem_ce` rises at T+1.
  - It is held until the cycle `mem_rdata_valid` or `mem_write_respone` is sampled high (cycle R).
  - It drops at R+1, and the response pulse is at R+1.
- `mem_*` outputs are registered and stable for the whole time `mem_ce=1`.
- Back-to-back: if `ce` is still high in the IDLE cycle after a response, it is a new request. The MEM stage deasserts `ce` on fire.
- Reset asserted mid-transaction: the FSM returns to IDLE and `mem_ce` drops next cycle. Any late bridge pulse afterwards is ignored (IDLE rule).

## Test plan
- Cold read: after reset, read `0x1C000040`, bridge returns `0x12345678` after 3 cycles. Expect `mem_ce` high until the valid cycle, `rdata_valid` one cycle later with `0x12345678`. Re-read the same address: `rdata_valid` at T+1 and `mem_ce` stays 0.
- Partial write hit: line `0x1C000040`=`0x12345678`. Write `wdata=0xAABBCCDD`, `wmask=4'b0101`. Expect a bridge write with the same data and mask, then `write_finish`. A following read hits and returns `0x12BB56DD`.
- Write miss, no allocate: write `0x1C000080` while invalid. Expect `write_finish`. The next read of `0x1C000080` issues a bridge read, so `mem_ce=1`.
- Index conflict (`INDEX_WIDTH=6`): read `0x1C000000` (data `0x1`), then `0x1C000100` (data `0x2`), then `0x1C000000` again. Expect the third access to miss and return `0x1`.
- Uncached: read `0xA0000000` twice, bridge returns `0x5` then `0x6`. Expect two bridge reads and `rdata` `0x5` then `0x6`.
- Reset mid-miss: assert `reset` while in RD_MISS, then pulse `mem_rdata_valid` after reset. Expect no `rdata_valid`, all valid bits cleared, and the next read misses.
